// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: single-outstanding imem handshake, IF/ID register load,
// static prediction (JAL taken, backward branch taken), stall hold and EX redirect.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_pred_taken
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] pend_reg, pend_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic        buf_pred_reg, buf_pred_next;
  logic [31:0] buf_npc_reg, buf_npc_next;
  logic        valid_reg, valid_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        pred_reg, pred_next;

  // Static prediction on the word returning this cycle, at the outstanding address.
  logic [31:0] j_imm, b_imm, fetch_npc;
  logic        fetch_pred;

  assign j_imm = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                  imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign b_imm = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                  imem_rdata[30:25], imem_rdata[11:8], 1'b0};

  always_comb begin
    fetch_pred = 1'b0;
    fetch_npc  = addr_reg + 32'd4;
    if (imem_rdata[6:0] == 7'b1101111) begin
      fetch_pred = 1'b1;
      fetch_npc  = addr_reg + j_imm;
    end else if (imem_rdata[6:0] == 7'b1100011 && imem_rdata[31]) begin
      fetch_pred = 1'b1;
      fetch_npc  = addr_reg + b_imm;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    pend_next      = pend_reg;
    buf_pc_next    = buf_pc_reg;
    buf_instr_next = buf_instr_reg;
    buf_pred_next  = buf_pred_reg;
    buf_npc_next   = buf_npc_reg;
    valid_next     = valid_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    pred_next      = pred_reg;

    unique case (state_reg)
      S_IDLE: begin
        state_next = S_REQ;
        if (redirect_valid) begin
          addr_next  = redirect_pc;
          valid_next = 1'b0;
        end
      end

      S_REQ: begin
        if (redirect_valid) begin
          valid_next = 1'b0;
          if (imem_ack) begin
            addr_next = redirect_pc;
          end else begin
            // Address must stay put until the in-flight request completes.
            pend_next  = redirect_pc;
            state_next = S_DRAIN;
          end
        end else if (imem_ack) begin
          if (stall) begin
            buf_pc_next    = addr_reg;
            buf_instr_next = imem_rdata;
            buf_pred_next  = fetch_pred;
            buf_npc_next   = fetch_npc;
            state_next     = S_HOLD;
          end else begin
            valid_next = 1'b1;
            pc_next    = addr_reg;
            instr_next = imem_rdata;
            pred_next  = fetch_pred;
            addr_next  = fetch_npc;
          end
        end else if (!stall) begin
          valid_next = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          valid_next = 1'b0;
          addr_next  = redirect_pc;
          state_next = S_REQ;
        end else if (!stall) begin
          valid_next = 1'b1;
          pc_next    = buf_pc_reg;
          instr_next = buf_instr_reg;
          pred_next  = buf_pred_reg;
          addr_next  = buf_npc_reg;
          state_next = S_REQ;
        end
      end

      S_DRAIN: begin
        valid_next = 1'b0;
        if (redirect_valid) begin
          pend_next = redirect_pc;
        end
        if (imem_ack) begin
          addr_next  = redirect_valid ? redirect_pc : pend_reg;
          state_next = S_REQ;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= RESET_PC;
      pend_reg      <= '0;
      buf_pc_reg    <= '0;
      buf_instr_reg <= '0;
      buf_pred_reg  <= 1'b0;
      buf_npc_reg   <= '0;
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      instr_reg     <= '0;
      pred_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      pend_reg      <= pend_next;
      buf_pc_reg    <= buf_pc_next;
      buf_instr_reg <= buf_instr_next;
      buf_pred_reg  <= buf_pred_next;
      buf_npc_reg   <= buf_npc_next;
      valid_reg     <= valid_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      pred_reg      <= pred_next;
    end
  end

  assign imem_req         = (state_reg == S_REQ) || (state_reg == S_DRAIN);
  assign imem_addr        = addr_reg;
  assign if_id_valid      = valid_reg;
  assign if_id_pc         = pc_reg;
  assign if_id_instr      = instr_reg;
  assign if_id_pred_taken = pred_reg;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios from the fetch test plan, then a
// randomized run checked against an event-level reference model.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_pred_taken;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_pred_taken(if_id_pred_taken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic stl, input logic rv,
                       input logic [31:0] rpc, input logic [31:0] rdata);
    imem_ack = ack; stall = stl; redirect_valid = rv;
    redirect_pc = rpc; imem_rdata = rdata;
  endtask

  // Move the fetch stream to pc via a redirect coinciding with an ack.
  task automatic jump_to(input logic [31:0] pc);
    drive(1, 0, 1, pc, NOP);
    tick();
    drive(0, 0, 0, 0, NOP);
  endtask

  // Reference prediction, built from the immediate field weights.
  function automatic void ref_predict(input logic [31:0] w, input logic [31:0] p,
                                      output logic [31:0] nxt, output logic tk);
    int imm;
    if (w[6:0] == 7'h6F) begin
      imm = (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
      if (w[31]) imm -= (1 << 20);
      nxt = p + 32'(imm);
      tk  = 1'b1;
    end else if (w[6:0] == 7'h63 && w[31]) begin
      imm = (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1) - 4096;
      nxt = p + 32'(imm);
      tk  = 1'b1;
    end else begin
      nxt = p + 32'd4;
      tk  = 1'b0;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, NOP);
    tick(); tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h100 || if_id_valid !== 1'b0 ||
        if_id_pc !== 32'h0 || if_id_instr !== 32'h0 || if_id_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_state req=%b addr=%h v=%b pc=%h ins=%h pr=%b expected 0 00000100 0 0 0 0",
               imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, if_id_pred_taken);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL first_req req=%b addr=%h expected 1 00000100", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, NOP);
      tick();
      checks++;
      if (imem_addr !== 32'h104 + 32'(4 * i) || if_id_valid !== 1'b1 ||
          if_id_pc !== 32'h100 + 32'(4 * i) || if_id_instr !== NOP || if_id_pred_taken !== 1'b0) begin
        errors++;
        $display("FAIL seq_%0d addr=%h v=%b pc=%h pr=%b expected %h 1 %h 0", i, imem_addr,
                 if_id_valid, if_id_pc, if_id_pred_taken, 32'h104 + 32'(4 * i), 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_jal();
    logic [31:0] words [2];
    logic [31:0] exp_next [2];
    words[0] = 32'h0100_006F; exp_next[0] = 32'h210;
    words[1] = 32'hFF1F_F06F; exp_next[1] = 32'h1F0;
    for (int i = 0; i < 2; i++) begin
      jump_to(32'h200);
      checks++;
      if (imem_addr !== 32'h200 || if_id_valid !== 1'b0) begin
        errors++;
        $display("FAIL jal_redirect_%0d addr=%h v=%b expected 00000200 0", i, imem_addr, if_id_valid);
      end
      drive(1, 0, 0, 0, words[i]);
      tick();
      checks++;
      if (imem_addr !== exp_next[i] || if_id_pc !== 32'h200 || if_id_pred_taken !== 1'b1 ||
          if_id_instr !== words[i]) begin
        errors++;
        $display("FAIL jal_%0d addr=%h pc=%h pr=%b expected %h 00000200 1", i, imem_addr,
                 if_id_pc, if_id_pred_taken, exp_next[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] words [2];
    logic [31:0] exp_next [2];
    logic        exp_pred [2];
    words[0] = 32'hFE00_0CE3; exp_next[0] = 32'h2F8; exp_pred[0] = 1'b1;
    words[1] = 32'h0000_0463; exp_next[1] = 32'h304; exp_pred[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      jump_to(32'h300);
      drive(1, 0, 0, 0, words[i]);
      tick();
      checks++;
      if (imem_addr !== exp_next[i] || if_id_pc !== 32'h300 || if_id_pred_taken !== exp_pred[i]) begin
        errors++;
        $display("FAIL branch_%0d addr=%h pc=%h pr=%b expected %h 00000300 %b", i, imem_addr,
                 if_id_pc, if_id_pred_taken, exp_next[i], exp_pred[i]);
      end
    end
  endtask

  task automatic test_stall();
    jump_to(32'h3C);
    drive(1, 0, 0, 0, NOP);
    tick();
    drive(1, 1, 0, 0, 32'h0050_0093);
    tick();
    drive(0, 1, 0, 0, NOP);
    checks++;
    if (imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'h3C) begin
      errors++;
      $display("FAIL stall_hold req=%b v=%b pc=%h expected 0 1 0000003c", imem_req, if_id_valid, if_id_pc);
    end
    tick();
    checks++;
    if (imem_req !== 1'b0 || if_id_pc !== 32'h3C) begin
      errors++;
      $display("FAIL stall_hold2 req=%b pc=%h expected 0 0000003c", imem_req, if_id_pc);
    end
    drive(0, 0, 0, 0, NOP);
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h44 || if_id_valid !== 1'b1 ||
        if_id_pc !== 32'h40 || if_id_instr !== 32'h0050_0093) begin
      errors++;
      $display("FAIL stall_release req=%b addr=%h v=%b pc=%h ins=%h expected 1 00000044 1 00000040 00500093",
               imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_redirect_drain();
    jump_to(32'h7C);
    drive(1, 0, 0, 0, NOP);
    tick();
    drive(0, 0, 1, 32'h500, NOP);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(i == 2, 0, 0, 0, 32'h0100_006F);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80 || if_id_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_wait_%0d req=%b addr=%h v=%b expected 1 00000080 0", i, imem_req, imem_addr, if_id_valid);
      end
      tick();
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h500 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_done req=%b addr=%h v=%b expected 1 00000500 0", imem_req, imem_addr, if_id_valid);
    end
    drive(1, 0, 0, 0, NOP);
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h500 || imem_addr !== 32'h504) begin
      errors++;
      $display("FAIL drain_first v=%b pc=%h addr=%h expected 1 00000500 00000504", if_id_valid, if_id_pc, imem_addr);
    end
  endtask

  task automatic test_redirect_hold();
    drive(1, 1, 0, 0, NOP);
    tick();
    drive(0, 1, 1, 32'h600, NOP);
    tick();
    drive(0, 0, 0, 0, NOP);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h600 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_redirect req=%b addr=%h v=%b expected 1 00000600 0", imem_req, imem_addr, if_id_valid);
    end
  endtask

  task automatic test_random();
    logic        m_started, m_held, m_discard, m_valid, m_pred, h_pred, tk;
    logic [31:0] m_addr, m_pend, m_pc, m_instr, h_pc, h_instr, h_next, nxt;
    logic        m_req;
    logic [31:0] w;

    rst = 1'b1;
    drive(0, 0, 0, 0, NOP);
    tick(); tick();
    rst = 1'b0;
    m_started = 0; m_held = 0; m_discard = 0; m_valid = 0; m_pred = 0; h_pred = 0;
    m_addr = 32'h100; m_pend = 0; m_pc = 0; m_instr = 0; h_pc = 0; h_instr = 0; h_next = 0;

    for (int n = 0; n < 3000; n++) begin
      m_req = m_started && !m_held;
      checks++;
      if (imem_req !== m_req || imem_addr !== m_addr || if_id_valid !== m_valid ||
          (m_valid && (if_id_pc !== m_pc || if_id_instr !== m_instr || if_id_pred_taken !== m_pred))) begin
        errors++;
        $display("FAIL rand_cycle_%0d req=%b addr=%h v=%b pc=%h ins=%h pr=%b expected %b %h %b %h %h %b",
                 n, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, if_id_pred_taken,
                 m_req, m_addr, m_valid, m_pc, m_instr, m_pred);
      end

      case ($urandom_range(0, 3))
        0: w = $urandom;
        1: w = ($urandom & 32'hFFFF_FF80) | 32'h6F;
        2: w = ($urandom & 32'hFFFF_FF80) | 32'h63;
        default: w = NOP;
      endcase
      rst = ($urandom_range(0, 199) == 0);
      drive(m_req && ($urandom_range(0, 2) != 0), $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC, w);
      tick();

      if (rst) begin
        m_started = 0; m_held = 0; m_discard = 0; m_valid = 0; m_pred = 0; h_pred = 0;
        m_addr = 32'h100; m_pend = 0; m_pc = 0; m_instr = 0;
      end else if (!m_started) begin
        m_started = 1;
        if (redirect_valid) begin m_addr = redirect_pc; m_valid = 0; end
      end else if (m_discard) begin
        m_valid = 0;
        if (redirect_valid) m_pend = redirect_pc;
        if (imem_ack) begin m_addr = m_pend; m_discard = 0; end
      end else if (m_held) begin
        if (redirect_valid) begin
          m_held = 0; m_valid = 0; m_addr = redirect_pc;
        end else if (!stall) begin
          m_held = 0; m_valid = 1; m_pc = h_pc; m_instr = h_instr; m_pred = h_pred; m_addr = h_next;
        end
      end else if (redirect_valid) begin
        m_valid = 0;
        if (imem_ack) m_addr = redirect_pc;
        else begin m_discard = 1; m_pend = redirect_pc; end
      end else if (imem_ack) begin
        ref_predict(imem_rdata, m_addr, nxt, tk);
        if (stall) begin
          m_held = 1; h_pc = m_addr; h_instr = imem_rdata; h_pred = tk; h_next = nxt;
        end else begin
          m_valid = 1; m_pc = m_addr; m_instr = imem_rdata; m_pred = tk; m_addr = nxt;
        end
      end else if (!stall) begin
        m_valid = 0;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, NOP);
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_stall();
    test_redirect_drain();
    test_redirect_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer for the IF stage of the pipelined RV32I core. Generates the fetch PC, runs a single-outstanding request/acknowledge handshake with instruction memory and loads the IF/ID pipeline register. It applies static prediction by decoding the J-type and B-type immediates of each fetched word: JAL is always taken, backward branches are taken. It honours stall from the hazard unit and redirect/flush from EX.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  request complete; imem_rdata valid this cycle; may assert in the same cycle as imem_req
- imem_rdata  in  32  fetched instruction word
- stall  in  1  hazard unit: hold IF/ID and stop loading
- redirect_valid  in  1  EX mispredict/JALR: flush and refetch
- redirect_pc  in  32  corrected fetch address
- if_id_valid  out  1  IF/ID contents are a live instruction
- if_id_pc  out  32  PC of IF/ID instruction
- if_id_instr  out  32  IF/ID instruction word
- if_id_pred_taken  out  1  fetch predicted a taken control transfer

## Operation
- States:
  - S_IDLE: after reset, no request.
  - S_REQ: imem_req=1.
  - S_HOLD: a word is captured while stalled, imem_req=0.
  - S_DRAIN: a redirect arrived with a request outstanding; the returning word is discarded.
- Prediction on a fetched word w at address p:
  - w[6:0]=7'b1101111 (JAL): next = p + J-imm, pred=1.
  - w[6:0]=7'b1100011 and w[31]=1: next = p + B-imm, pred=1.
  - Otherwise: next = p + 4, pred=0.
  - J-imm = sign-extended {w[31], w[19:12], w[20], w[30:21], 1'b0}.
  - B-imm = sign-extended {w[31], w[7], w[30:25], w[11:8], 1'b0}.
  - All PC arithmetic is 32-bit modulo 2^32.
- State transitions:
  - S_IDLE → S_REQ on the first cycle with rst=0; imem_addr=RESET_PC.
  - S_REQ, ack=1, stall=0: IF/ID loads {1, imem_addr, imem_rdata, pred}; imem_addr←next; stay in S_REQ.
  - S_REQ, ack=1, stall=1: capture the word, pc and pred into an internal buffer; go to S_HOLD.
  - S_HOLD, stall=0: IF/ID loads from the buffer; imem_addr←buffered next; go to S_REQ.
  - S_REQ, ack=0, stall=0: if_id_valid←0 (bubble).
- Stall=1, no redirect: all if_id_* outputs hold.
- Redirect (highest priority, overrides stall in every state):
  - if_id_valid←0.
  - From S_REQ with ack=1, S_HOLD or S_IDLE: discard any captured word; imem_addr←redirect_pc; go to S_REQ.
  - From S_REQ with ack=0: keep imem_req/imem_addr unchanged (protocol); latch redirect_pc as pending; go to S_DRAIN.
  - In S_DRAIN, a further redirect overwrites the pending PC.
  - S_DRAIN, ack=1: discard rdata; imem_addr←pending; go to S_REQ.
- At most one request is outstanding. imem_addr never changes while imem_req=1 and ack=0.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_instr=0, if_id_pred_taken=0.
  - State S_IDLE; buffer and pending PC cleared.
- First imem_req=1 appears in the cycle after rst deasserts.
- Fetch-to-decode latency: ack in cycle t → if_id_* valid from cycle t+1; the next request's address is presented in cycle t+1.
- Zero-wait memory (ack with req) sustains 1 instruction/cycle.
- Redirect in cycle t with no outstanding wait:
  - Request to redirect_pc in cycle t+1.
  - First redirected instruction in IF/ID no earlier than t+2.
- rst asserted mid-request: all state returns to reset values at the next edge; the in-flight ack is ignored.

## Test plan
- Reset + zero-wait sequential: RESET_PC=0x100, ack always 1, ADDI words → imem_addr 0x100, 0x104, 0x108 on consecutive cycles; if_id_pc follows one cycle later with pred=0.
- JAL prediction: word 0x0100006F (jal x0,+16) at 0x200 → next imem_addr 0x210, if_id_pred_taken=1. Word 0xFF1FF06F (jal x0,-16) at 0x200 → next imem_addr 0x1F0.
- Branches: beq with w[31]=1, imm -8, at 0x300 → next 0x2F8, pred=1. Forward beq with imm +8 → next 0x304, pred=0.
- Stall during ack: stall=1 when word at 0x40 acks → imem_req drops, IF/ID holds the old value; stall=0 → IF/ID shows pc 0x40, then a request to 0x44.
- Redirect during wait: request 0x80 pending with ack=0, redirect_pc=0x500. Ack arrives 3 cycles later with data → data discarded, imem_addr 0x80 held until ack, then 0x500; if_id_valid=0 throughout.
- Redirect with stall=1 in S_HOLD, redirect_pc=0x600 → buffer dropped, if_id_valid=0, next request 0x600.
